cpu_io_timer: RTL and testbench

Memory-mapped I/O responder for the cpu6502 bus. It decodes an 8-byte window at `BASE` and provides an output port, a synchronised input port, a 16-bit interval timer, and an interrupt flag/enable pair. It drives the CPU `irq` and `nmi` inputs. It replaces the ad-hoc single-register I/O port on the CPU bus, sits beside `memory`, and has its read data muxed onto `cpu_data_in` whenever `hit` is high.

---
 rtl/cpu_io_pkg.sv | 28 ++
 rtl/io_timer16.sv | 73 +++++++
 rtl/cpu_io_timer.sv | 150 +++++++++++++++
 tb/tb_cpu_io_timer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the cpu6502 I/O and timer block: register offsets,
// interrupt flag bit positions and the CTRL register layout.
package cpu_io_pkg;

   localparam logic [2:0] OFS_PORT_OUT = 3'd0;
   localparam logic [2:0] OFS_PORT_IN  = 3'd1;
   localparam logic [2:0] OFS_TLO      = 3'd2;
   localparam logic [2:0] OFS_THI      = 3'd3;
   localparam logic [2:0] OFS_CTRL     = 3'd4;
   localparam logic [2:0] OFS_IFR      = 3'd5;
   localparam logic [2:0] OFS_IER      = 3'd6;
   localparam logic [2:0] OFS_NMI      = 3'd7;

   localparam int IF_TIMER = 0;
   localparam int IF_EDGE  = 1;
   localparam int IF_SOFT  = 2;
   localparam int IF_BITS  = 3;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_CONT = 1;

   // Packed so that bit CTRL_CONT is cont and bit CTRL_RUN is run.
   typedef struct packed {
      logic cont;
      logic run;
   } ctrl_t;

endpackage

// File: rtl/io_timer16.sv
// 16-bit interval timer: prescaler, reload latch and down-counter with an
// underflow pulse. A load always beats a coincident underflow.
module io_timer16 #(
   parameter int PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        latch_lo_we,
   input  logic        load,
   input  logic [7:0]  wdata,
   input  logic        run,
   input  logic        continuous,
   output logic [15:0] count,
   output logic        underflow
);

   localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

   logic [7:0]  pre_q, pre_d;
   logic [15:0] latch_q, latch_d;
   logic [15:0] count_q, count_d;
   logic        tick;

   assign tick      = run && (pre_q == PRE_MAX);
   assign underflow = tick && (count_q == 16'd0) && !load;
   assign count     = count_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      pre_d   = pre_q;
      latch_d = latch_q;
      count_d = count_q;

      if (run) begin
         pre_d = tick ? 8'd0 : pre_q + 8'd1;
      end

      if (tick) begin
         if (count_q == 16'd0) begin
            count_d = continuous ? latch_q : 16'd0;
         end else begin
            count_d = count_q - 16'd1;
         end
      end

      if (latch_lo_we) begin
         latch_d[7:0] = wdata;
      end

      // The high-byte write completes the latch and restarts the count from it.
      if (load) begin
         latch_d[15:8] = wdata;
         count_d       = {wdata, latch_q[7:0]};
         pre_d         = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q   <= 8'd0;
         latch_q <= 16'd0;
         count_q <= 16'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         pre_q   <= pre_d;
         latch_q <= latch_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cpu_io_timer.sv
// Memory-mapped I/O responder on the cpu6502 bus: output port, synchronised
// input port, interval timer, interrupt flags/enables and an NMI pulse.
module cpu_io_timer
   import cpu_io_pkg::*;
#(
   parameter logic [15:0] BASE       = 16'hbff8,
   parameter int          PRESCALE   = 1,
   parameter int          NMI_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        write,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        hit,
   input  logic [7:0]  port_in,
   output logic [7:0]  port_out,
   output logic        irq,
   output logic        nmi
);

   localparam int NW = $clog2(NMI_CYCLES + 1);

   logic [2:0]         ofs;
   logic               wr_en;
   logic               we_port, we_tlo, we_thi, we_ctrl, we_ifr, we_ier, we_nmi;

   logic [7:0]         port_out_q, port_out_d;
   logic [7:0]         sync1_q, sync1_d;
   logic [7:0]         sync2_q, sync2_d;
   logic               edge_prev_q, edge_prev_d;
   ctrl_t              ctrl_q, ctrl_d;
   logic [IF_BITS-1:0] ifr_q, ifr_d;
   logic [IF_BITS-1:0] ier_q, ier_d;
   logic               irq_q, irq_d;
   logic [NW-1:0]      nmi_cnt_q, nmi_cnt_d;
   logic               nmi_q, nmi_d;

   logic [15:0]        timer_count;
   logic               timer_underflow;
   logic               port_fall;

   assign hit   = (address[15:3] == BASE[15:3]);
   assign ofs   = address[2:0];
   assign wr_en = hit && write;

   assign we_port = wr_en && (ofs == OFS_PORT_OUT);
   assign we_tlo  = wr_en && (ofs == OFS_TLO);
   assign we_thi  = wr_en && (ofs == OFS_THI);
   assign we_ctrl = wr_en && (ofs == OFS_CTRL);
   assign we_ifr  = wr_en && (ofs == OFS_IFR);
   assign we_ier  = wr_en && (ofs == OFS_IER);
   assign we_nmi  = wr_en && (ofs == OFS_NMI);

   assign port_fall = edge_prev_q && !sync2_q[0];

   io_timer16 #(
      .PRESCALE(PRESCALE)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .latch_lo_we(we_tlo),
      .load       (we_thi),
      .wdata      (data_i),
      .run        (ctrl_q.run),
      .continuous (ctrl_q.cont),
      .count      (timer_count),
      .underflow  (timer_underflow)
   );

   always_comb begin
      port_out_d  = port_out_q;
      sync1_d     = port_in;
      sync2_d     = sync1_q;
      edge_prev_d = sync2_q[0];
      ctrl_d      = ctrl_q;
      ifr_d       = ifr_q;
      ier_d       = ier_q;
      nmi_cnt_d   = (nmi_cnt_q != '0) ? nmi_cnt_q - NW'(1) : '0;

      if (we_port) port_out_d = data_i;
      if (we_ier)  ier_d      = data_i[IF_BITS-1:0];

      // Later assignments win: underflow stop, then THI restart, then CTRL write.
      if (timer_underflow && !ctrl_q.cont) ctrl_d.run = 1'b0;
      if (we_thi)  ctrl_d.run = 1'b1;
      if (we_ctrl) ctrl_d     = ctrl_t'(data_i[1:0]);

      // Clears first so that a same-cycle set event overrides them.
      if (we_ifr) begin
         ifr_d[IF_TIMER] = ifr_q[IF_TIMER] & ~data_i[IF_TIMER];
         ifr_d[IF_EDGE]  = ifr_q[IF_EDGE]  & ~data_i[IF_EDGE];
         ifr_d[IF_SOFT]  = ifr_q[IF_SOFT]  ^  data_i[IF_SOFT];
      end
      if (we_thi)          ifr_d[IF_TIMER] = 1'b0;
      if (timer_underflow) ifr_d[IF_TIMER] = 1'b1;
      if (port_fall)       ifr_d[IF_EDGE]  = 1'b1;

      if (we_nmi) nmi_cnt_d = NW'(NMI_CYCLES);

      irq_d = |(ifr_q & ier_q);
      nmi_d = (nmi_cnt_d != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port_out_q  <= 8'h00;
         sync1_q     <= 8'h00;
         sync2_q     <= 8'h00;
         edge_prev_q <= 1'b0;
         ctrl_q      <= '0;
         ifr_q       <= '0;
         ier_q       <= '0;
         irq_q       <= 1'b0;
         nmi_cnt_q   <= '0;
         nmi_q       <= 1'b0;
      end else begin
         port_out_q  <= port_out_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         edge_prev_q <= edge_prev_d;
         ctrl_q      <= ctrl_d;
         ifr_q       <= ifr_d;
         ier_q       <= ier_d;
         irq_q       <= irq_d;
         nmi_cnt_q   <= nmi_cnt_d;
         nmi_q       <= nmi_d;
      end
   end

   always_comb begin
      data_o = 8'h00;
      case (ofs)
         OFS_PORT_OUT: data_o = port_out_q;
         OFS_PORT_IN:  data_o = sync2_q;
         OFS_TLO:      data_o = timer_count[7:0];
         OFS_THI:      data_o = timer_count[15:8];
         OFS_CTRL:     data_o = {6'b0, ctrl_q};
         OFS_IFR:      data_o = {irq_q, 4'b0, ifr_q};
         OFS_IER:      data_o = {5'b0, ier_q};
         default:      data_o = 8'h00;
      endcase
   end

   assign port_out = port_out_q;
   assign irq      = irq_q;
   assign nmi      = nmi_q;

endmodule

// File: tb/tb_cpu_io_timer.sv
// Directed bench for cpu_io_timer: hand-computed expectations checked with
// immediate assertions, default parameters (BASE bff8, PRESCALE 1, NMI 4).
module tb_cpu_io_timer;

   logic        clk;
   logic        reset;
   logic [15:0] address;
   logic        write;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        hit;
   logic [7:0]  port_in;
   logic [7:0]  port_out;
   logic        irq;
   logic        nmi;

   int checks = 0;
   int errors = 0;

   cpu_io_timer dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .write   (write),
      .data_i  (data_i),
      .data_o  (data_o),
      .hit     (hit),
      .port_in (port_in),
      .port_out(port_out),
      .irq     (irq),
      .nmi     (nmi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1ns past the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      address = a;
      data_i  = d;
      write   = 1'b1;
      step(1);
      write   = 1'b0;
      address = 16'h0000;
   endtask

   task automatic chk_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      address = a;
      #1;
      check(tag, {8'h00, data_o}, {8'h00, exp});
   endtask

   initial begin
      reset   = 1'b0;
      address = 16'h0000;
      write   = 1'b0;
      data_i  = 8'h00;
      port_in = 8'h00;
      #12;
      reset = 1'b1;
      step(1);

      // Reset state and decode window
      check("rst_port_out", {8'h00, port_out}, 16'h0000);
      check("rst_irq", {15'h0, irq}, 16'h0000);
      check("rst_nmi", {15'h0, nmi}, 16'h0000);
      address = 16'hbffc;
      #1;
      check("hit_in_window", {15'h0, hit}, 16'h0001);
      check("rst_ctrl_read", {8'h00, data_o}, 16'h0000);
      address = 16'hbff7;
      #1;
      check("hit_below_window", {15'h0, hit}, 16'h0000);

      // Output port and synchronised input port
      wr(16'hbff8, 8'ha5);
      check("port_out_a5", {8'h00, port_out}, 16'h00a5);
      chk_rd("port_out_read", 16'hbff8, 8'ha5);
      port_in = 8'h3c;
      step(1);
      chk_rd("port_in_1edge", 16'hbff9, 8'h00);
      step(1);
      chk_rd("port_in_2edge", 16'hbff9, 8'h3c);

      // Continuous timer, latch 3: underflow every 4 ticks
      wr(16'hbffe, 8'h01);
      wr(16'hbffa, 8'h03);
      wr(16'hbffb, 8'h00);
      wr(16'hbffc, 8'h03);
      chk_rd("cont_count_n1", 16'hbffa, 8'h02);
      chk_rd("cont_ctrl", 16'hbffc, 8'h03);
      step(2);
      chk_rd("cont_ifr_before", 16'hbffd, 8'h00);
      step(1);
      chk_rd("cont_ifr_set", 16'hbffd, 8'h01);
      check("cont_irq_not_yet", {15'h0, irq}, 16'h0000);
      step(1);
      chk_rd("cont_ifr_irq", 16'hbffd, 8'h81);
      check("cont_irq_high", {15'h0, irq}, 16'h0001);
      chk_rd("cont_reload_count", 16'hbffa, 8'h02);
      wr(16'hbffd, 8'h01);
      check("ifr_clear_irq_edge1", {15'h0, irq}, 16'h0001);
      step(1);
      check("ifr_clear_irq_edge2", {15'h0, irq}, 16'h0000);
      step(1);
      chk_rd("cont_second_underflow", 16'hbffd, 8'h01);

      // One-shot, latch 2
      wr(16'hbffc, 8'h00);
      wr(16'hbffd, 8'h03);
      wr(16'hbffa, 8'h02);
      wr(16'hbffb, 8'h00);
      step(2);
      chk_rd("oneshot_running", 16'hbffc, 8'h01);
      step(1);
      chk_rd("oneshot_ctrl_stopped", 16'hbffc, 8'h00);
      chk_rd("oneshot_count0", 16'hbffa, 8'h00);
      chk_rd("oneshot_ifr", 16'hbffd, 8'h01);
      step(2);
      chk_rd("oneshot_hold_lo", 16'hbffa, 8'h00);
      chk_rd("oneshot_hold_hi", 16'hbffb, 8'h00);
      check("oneshot_irq", {15'h0, irq}, 16'h0001);

      // THI write coinciding with an underflow
      wr(16'hbffd, 8'h01);
      wr(16'hbffb, 8'h00);
      step(2);
      wr(16'hbffb, 8'h00);
      chk_rd("thi_vs_uf_ifr", 16'hbffd, 8'h00);
      chk_rd("thi_vs_uf_count", 16'hbffa, 8'h02);
      chk_rd("thi_vs_uf_run", 16'hbffc, 8'h01);
      wr(16'hbffc, 8'h00);

      // Software flag toggle-to-set, then clear
      wr(16'hbffd, 8'h04);
      chk_rd("soft_set", 16'hbffd, 8'h04);
      wr(16'hbffd, 8'h04);
      chk_rd("soft_clear", 16'hbffd, 8'h00);

      // NMI pulse: exactly 4 cycles
      check("nmi_idle", {15'h0, nmi}, 16'h0000);
      wr(16'hbfff, 8'h00);
      check("nmi_c1", {15'h0, nmi}, 16'h0001);
      for (int i = 1; i <= 4; i++) begin
         step(1);
         check($sformatf("nmi_after_%0d", i), {15'h0, nmi}, (i < 4) ? 16'h0001 : 16'h0000);
      end
      chk_rd("nmi_read0", 16'hbfff, 8'h00);

      // Retrigger during pulse cycle 2: 6 contiguous high cycles
      wr(16'hbfff, 8'h00);
      check("nmi_rt_c1", {15'h0, nmi}, 16'h0001);
      step(1);
      check("nmi_rt_c2", {15'h0, nmi}, 16'h0001);
      wr(16'hbfff, 8'h00);
      check("nmi_rt_c3", {15'h0, nmi}, 16'h0001);
      for (int i = 1; i <= 4; i++) begin
         step(1);
         check($sformatf("nmi_rt_after_%0d", i), {15'h0, nmi}, (i < 4) ? 16'h0001 : 16'h0000);
      end

      // Falling edge on port_in[0] with IER=2
      port_in = 8'h3d;
      step(3);
      wr(16'hbffe, 8'h02);
      port_in = 8'h3c;
      step(2);
      chk_rd("edge_not_yet", 16'hbffd, 8'h00);
      step(1);
      chk_rd("edge_ifr1", 16'hbffd, 8'h02);
      check("edge_irq_not_yet", {15'h0, irq}, 16'h0000);
      step(1);
      check("edge_irq", {15'h0, irq}, 16'h0001);
      chk_rd("edge_ifr_irq", 16'hbffd, 8'h82);

      // Reset mid-count and mid-pulse
      wr(16'hbffa, 8'h10);
      wr(16'hbffb, 8'h00);
      wr(16'hbfff, 8'h00);
      check("pre_reset_nmi", {15'h0, nmi}, 16'h0001);
      reset = 1'b0;
      #1;
      check("reset_port_out", {8'h00, port_out}, 16'h0000);
      check("reset_irq", {15'h0, irq}, 16'h0000);
      check("reset_nmi", {15'h0, nmi}, 16'h0000);
      chk_rd("reset_count_lo", 16'hbffa, 8'h00);
      chk_rd("reset_ctrl", 16'hbffc, 8'h00);
      chk_rd("reset_ifr", 16'hbffd, 8'h00);
      chk_rd("reset_ier", 16'hbffe, 8'h00);
      reset = 1'b1;
      step(2);
      chk_rd("post_reset_count", 16'hbffa, 8'h00);
      check("post_reset_nmi", {15'h0, nmi}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
